// File: rtl/pulse_seq_cmd_loader.sv
// Purpose: assembles host bytes into sequencer register writes and run-control commands.
// Latency: strobe and new value appear 2 cycles after the last payload byte is accepted.
// Backpressure: byte_ready is low only in COMMIT and in the cycle an inter-byte timeout fires.
module pulse_seq_cmd_loader #(
  parameter int N_SEQ   = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic [31:0]      value,
  output logic [N_SEQ-1:0] set_initial_state,
  output logic [N_SEQ-1:0] set_initial_count,
  output logic [N_SEQ-1:0] set_hi_count,
  output logic [N_SEQ-1:0] set_lo_count,
  output logic             operate,
  output logic             busy,
  output logic             err_bad_op,
  output logic             err_bad_index,
  output logic             err_timeout
);

  // Idle counter only needs to reach TIMEOUT; it is cleared when it gets there.
  localparam int             CW  = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  TMO = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PAY0   = 3'd1,
    PAY1   = 3'd2,
    PAY2   = 3'd3,
    PAY3   = 3'd4,
    COMMIT = 3'd5
  } state_t;

  // Opcode command field encodings.
  localparam logic [1:0] CMD_WRITE = 2'b00;
  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_NOP   = 2'b10;
  localparam logic [1:0] CMD_RSVD  = 2'b11;

  state_t          state;
  logic [CW-1:0]   idle_cnt;
  logic [1:0]      reg_sel;
  logic [3:0]      seq_idx;
  logic [31:0]     shadow;

  logic            in_payload;
  logic            timeout_hit;
  logic            accept;
  logic            idx_ok;
  logic [N_SEQ-1:0] idx_onehot;

  assign in_payload  = (state == PAY0) || (state == PAY1) ||
                       (state == PAY2) || (state == PAY3);
  // The abort cycle refuses any byte so a late byte cannot start a new command.
  assign timeout_hit = in_payload && (idle_cnt == TMO);
  assign byte_ready  = (state == IDLE) || (in_payload && !timeout_hit);
  assign busy        = (state != IDLE);
  assign accept      = byte_valid && byte_ready;

  // Full 4-bit index compared, so indices aliasing onto a small bank are still rejected.
  assign idx_ok = ({1'b0, seq_idx} < 5'(N_SEQ));

  // Decode the latched sequencer index into a one-hot strobe pattern.
  always_comb begin
    idx_onehot = '0;
    for (int i = 0; i < N_SEQ; i++) begin
      idx_onehot[i] = (seq_idx == 4'(i));
    end
  end

  // Command FSM: byte collection, commit of value and strobes, error pulses, operate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      idle_cnt          <= '0;
      reg_sel           <= '0;
      seq_idx           <= '0;
      shadow            <= '0;
      value             <= '0;
      set_initial_state <= '0;
      set_initial_count <= '0;
      set_hi_count      <= '0;
      set_lo_count      <= '0;
      operate           <= 1'b0;
      err_bad_op        <= 1'b0;
      err_bad_index     <= 1'b0;
      err_timeout       <= 1'b0;
    end else begin
      // Strobes and error flags are single-cycle pulses unless re-set below.
      set_initial_state <= '0;
      set_initial_count <= '0;
      set_hi_count      <= '0;
      set_lo_count      <= '0;
      err_bad_op        <= 1'b0;
      err_bad_index     <= 1'b0;
      err_timeout       <= 1'b0;

      case (state)
        IDLE: begin
          idle_cnt <= '0;
          if (accept) begin
            case (byte_in[7:6])
              CMD_WRITE: begin
                reg_sel <= byte_in[5:4];
                seq_idx <= byte_in[3:0];
                shadow  <= '0;
                state   <= PAY0;
              end
              CMD_RUN:  operate    <= byte_in[0];
              CMD_NOP:  ;
              CMD_RSVD: err_bad_op <= 1'b1;
              default:  ;
            endcase
          end
        end

        PAY0, PAY1, PAY2, PAY3: begin
          if (timeout_hit) begin
            // Abandon the partial word; value and strobes stay untouched.
            state       <= IDLE;
            idle_cnt    <= '0;
            shadow      <= '0;
            err_timeout <= 1'b1;
          end else if (accept) begin
            idle_cnt <= '0;
            case (state)
              PAY0: begin
                shadow[7:0]   <= byte_in;
                state         <= PAY1;
              end
              PAY1: begin
                shadow[15:8]  <= byte_in;
                state         <= PAY2;
              end
              PAY2: begin
                shadow[23:16] <= byte_in;
                state         <= PAY3;
              end
              PAY3: begin
                shadow[31:24] <= byte_in;
                state         <= COMMIT;
              end
              default: state  <= IDLE;
            endcase
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end

        COMMIT: begin
          // value and strobe land in the same cycle so sequencers see a stable word.
          value    <= shadow;
          state    <= IDLE;
          idle_cnt <= '0;
          if (idx_ok) begin
            case (reg_sel)
              2'd0:    set_initial_state <= idx_onehot;
              2'd1:    set_initial_count <= idx_onehot;
              2'd2:    set_hi_count      <= idx_onehot;
              default: set_lo_count      <= idx_onehot;
            endcase
          end else begin
            err_bad_index <= 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          idle_cnt <= '0;
        end
      endcase
    end
  end

endmodule
